// File: rtl/ccm_pass_scheduler_if.sv
// ccm_pass_scheduler_if
//   Bundles the host start/status signals, the kernel-reader and cluster
//   handshakes and the per-pass descriptor of ccm_pass_scheduler.
//   master : environment side (host, kernel reader, cluster array)
//   slave  : the scheduler itself
//   op_start, cfg_num_kernel             host -> scheduler
//   status, op_done, op_err              scheduler -> host
//   kern_rd_start / kern_rd_work         scheduler <-> kernel reader
//   cluster_start / cluster_work         scheduler <-> cluster array
//   kern_base, kern_count, pass_idx      current pass descriptor
interface ccm_pass_scheduler_if #(
  parameter int KERN_W = 8,
  parameter int CNT_W  = 5,
  parameter int PASS_W = 3
);
  logic              op_start;
  logic [KERN_W-1:0] cfg_num_kernel;
  logic              status;
  logic              op_done;
  logic              op_err;
  logic              kern_rd_start;
  logic              kern_rd_work;
  logic              cluster_start;
  logic              cluster_work;
  logic [KERN_W-1:0] kern_base;
  logic [CNT_W-1:0]  kern_count;
  logic [PASS_W-1:0] pass_idx;

  modport master (
    output op_start, cfg_num_kernel, kern_rd_work, cluster_work,
    input  status, op_done, op_err, kern_rd_start, cluster_start,
           kern_base, kern_count, pass_idx
  );

  modport slave (
    input  op_start, cfg_num_kernel, kern_rd_work, cluster_work,
    output status, op_done, op_err, kern_rd_start, cluster_start,
           kern_base, kern_count, pass_idx
  );
endinterface

// File: rtl/ccm_pass_scheduler.sv
// ccm_pass_scheduler
//   Sequencer for the CCM kernel-load / cluster-compute pair. One operation of
//   N kernels is split into passes of at most KERN_PER_PASS kernels; each pass
//   issues one kernel read, waits for it, then one cluster run, waits for it.
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : ccm_pass_scheduler_if.slave (host, reader, cluster, pass descriptor)
module ccm_pass_scheduler #(
  parameter int KERN_W        = 8,
  parameter int KERN_PER_PASS = 16,
  parameter int MAX_PASS      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  ccm_pass_scheduler_if.slave   bus
);
  localparam int CNT_W    = $clog2(KERN_PER_PASS) + 1;
  localparam int PASS_W   = $clog2(MAX_PASS);
  localparam int MAX_KERN = MAX_PASS * KERN_PER_PASS;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CHECK   = 3'd1;
  localparam logic [2:0] S_LD_REQ  = 3'd2;
  localparam logic [2:0] S_LD_WAIT = 3'd3;
  localparam logic [2:0] S_CL_REQ  = 3'd4;
  localparam logic [2:0] S_CL_WAIT = 3'd5;
  localparam logic [2:0] S_NEXT    = 3'd6;
  localparam logic [2:0] S_DONE    = 3'd7;

  logic [2:0]        state_q, state_d;
  logic [KERN_W-1:0] num_q,   num_d;
  logic [KERN_W-1:0] base_q,  base_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic [PASS_W-1:0] pass_q,  pass_d;
  logic              err_q,   err_d;

  logic [KERN_W-1:0] base_next;
  logic [KERN_W:0]   pass_end;
  logic              num_bad;

  // Size of a pass given the kernels still outstanding.
  function automatic logic [CNT_W-1:0] clamp_cnt(input logic [KERN_W-1:0] rem);
    if (rem > KERN_W'(KERN_PER_PASS)) return CNT_W'(KERN_PER_PASS);
    else                               return CNT_W'(rem);
  endfunction

  assign base_next = base_q + KERN_W'(KERN_PER_PASS);
  // One extra bit so a full-size op (base 112 + 16 = 128) compares cleanly.
  assign pass_end  = {1'b0, base_q} + (KERN_W+1)'(cnt_q);
  assign num_bad   = (num_q == '0) || ({1'b0, num_q} > (KERN_W+1)'(MAX_KERN));

  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    base_d  = base_q;
    cnt_d   = cnt_q;
    pass_d  = pass_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (bus.op_start) begin
          num_d   = bus.cfg_num_kernel;
          err_d   = 1'b0;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (num_bad) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          pass_d  = '0;
          base_d  = '0;
          cnt_d   = clamp_cnt(num_q);
          state_d = S_LD_REQ;
        end
      end
      S_LD_REQ:  state_d = S_LD_WAIT;
      S_LD_WAIT: if (!bus.kern_rd_work) state_d = S_CL_REQ;
      S_CL_REQ:  state_d = S_CL_WAIT;
      S_CL_WAIT: if (!bus.cluster_work) state_d = S_NEXT;
      S_NEXT: begin
        if (pass_end == {1'b0, num_q}) begin
          state_d = S_DONE;
        end else begin
          pass_d  = pass_q + 1'b1;
          base_d  = base_next;
          cnt_d   = clamp_cnt(num_q - base_next);
          state_d = S_LD_REQ;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      num_q   <= '0;
      base_q  <= '0;
      cnt_q   <= '0;
      pass_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      base_q  <= base_d;
      cnt_q   <= cnt_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
    end
  end

  assign bus.status        = (state_q != S_IDLE);
  assign bus.op_done       = (state_q == S_DONE);
  assign bus.kern_rd_start = (state_q == S_LD_REQ);
  assign bus.cluster_start = (state_q == S_CL_REQ);
  assign bus.op_err        = err_q;
  assign bus.kern_base     = base_q;
  assign bus.kern_count    = cnt_q;
  assign bus.pass_idx      = pass_q;
endmodule

// File: tb/tb_ccm_pass_scheduler.sv
// tb_ccm_pass_scheduler
//   Self-checking bench for ccm_pass_scheduler: table of operations plus
//   hand-written sequences for mid-op start and reset during a cluster run.
module tb_ccm_pass_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ccm_pass_scheduler_if #(.KERN_W(8), .CNT_W(5), .PASS_W(3)) bus ();

  ccm_pass_scheduler #(.KERN_W(8), .KERN_PER_PASS(16), .MAX_PASS(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int base;
    int count;
    int idx;
  } pass_t;

  typedef struct {
    int n;
    int rd;
    int cl;
    int passes;
    int err;
    int last_base;
    int last_count;
  } vec_t;

  pass_t exp_q[$];
  pass_t cur;
  int    n_checks = 0;
  int    n_fail   = 0;
  int    exp_err  = 0;
  int    rd_pulses, cl_pulses, done_pulses;
  int    last_base, last_count;
  int    expect_rd = 1;
  int    rd_busy = 0, cl_busy = 0, rd_left, cl_left;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Reference pass list for an op of n kernels.
  task automatic push_exp(input int n);
    if (n >= 1 && n <= 128)
      for (int b = 0; b < n; b += 16)
        exp_q.push_back('{b, (n - b > 16) ? 16 : n - b, b / 16});
  endtask

  // Kernel reader / cluster models: busy for rd_busy / cl_busy cycles,
  // rising the cycle after the start pulse.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.kern_rd_work <= 1'b0;
      bus.cluster_work <= 1'b0;
      rd_left <= 0;
      cl_left <= 0;
    end else begin
      if (bus.kern_rd_start) begin
        bus.kern_rd_work <= (rd_busy > 0);
        rd_left <= rd_busy;
      end else if (rd_left > 1) begin
        rd_left <= rd_left - 1;
      end else begin
        rd_left <= 0;
        bus.kern_rd_work <= 1'b0;
      end
      if (bus.cluster_start) begin
        bus.cluster_work <= (cl_busy > 0);
        cl_left <= cl_busy;
      end else if (cl_left > 1) begin
        cl_left <= cl_left - 1;
      end else begin
        cl_left <= 0;
        bus.cluster_work <= 1'b0;
      end
    end
  end

  // Scoreboard monitor: each kern_rd_start pops the next expected pass.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.kern_rd_start && bus.cluster_start) check("start_overlap", 1, 0);
      if (bus.kern_rd_start) begin
        rd_pulses++;
        check("rd_alternation", expect_rd, 1);
        expect_rd = 0;
        if (exp_q.size() == 0) begin
          check("rd_unexpected", 1, 0);
        end else begin
          cur = exp_q.pop_front();
          check("rd_kern_base", int'(bus.kern_base), cur.base);
          check("rd_kern_count", int'(bus.kern_count), cur.count);
          check("rd_pass_idx", int'(bus.pass_idx), cur.idx);
          last_base  = int'(bus.kern_base);
          last_count = int'(bus.kern_count);
        end
      end
      if (bus.cluster_start) begin
        cl_pulses++;
        check("cl_alternation", expect_rd, 0);
        expect_rd = 1;
        check("cl_kern_base", int'(bus.kern_base), cur.base);
        check("cl_kern_count", int'(bus.kern_count), cur.count);
        check("cl_pass_idx", int'(bus.pass_idx), cur.idx);
      end
      if (bus.op_done) begin
        done_pulses++;
        check("done_op_err", int'(bus.op_err), exp_err);
        check("done_queue_empty", exp_q.size(), 0);
      end
    end
  end

  // Runs one op; if inject > 0, a second op_start (N=5) is pulsed that many
  // cycles into the op and must be ignored.
  task automatic run_op(input int n, input int rd, input int cl, input int inject);
    int np;
    int cyc;
    np = (n >= 1 && n <= 128) ? (n + 15) / 16 : 0;
    rd_busy = rd;
    cl_busy = cl;
    push_exp(n);
    exp_err = (n >= 1 && n <= 128) ? 0 : 1;
    rd_pulses = 0; cl_pulses = 0; done_pulses = 0; expect_rd = 1;
    @(posedge clk); #1;
    bus.op_start = 1'b1;
    bus.cfg_num_kernel = 8'(n);
    @(posedge clk); #1;
    bus.op_start = 1'b0;
    bus.cfg_num_kernel = 8'($urandom_range(0, 255));
    tick();
    check("status_at_t1", int'(bus.status), 1);
    tick();
    if (exp_err != 0) check("op_done_at_t2", int'(bus.op_done), 1);
    else              check("rd_start_at_t2", int'(bus.kern_rd_start), 1);
    cyc = 0;
    while (done_pulses == 0 && cyc < 3000) begin
      tick();
      cyc++;
      if (inject > 0 && cyc == inject) begin
        bus.op_start = 1'b1;
        bus.cfg_num_kernel = 8'd5;
      end else if (inject > 0 && cyc == inject + 1) begin
        bus.op_start = 1'b0;
      end
    end
    bus.op_start = 1'b0;
    if (done_pulses == 0) check("op_done_timeout", 0, 1);
    tick();
    tick();
    check("status_idle", int'(bus.status), 0);
    check("done_pulses", done_pulses, 1);
    check("rd_pulses", rd_pulses, np);
    check("cl_pulses", cl_pulses, np);
    check("op_err_hold", int'(bus.op_err), exp_err);
    exp_q.delete();
  endtask

  vec_t vecs[9];

  initial begin
    int cyc;
    vecs[0] = '{16,  3, 3, 1, 0,   0, 16};
    vecs[1] = '{40,  2, 4, 3, 0,  32,  8};
    vecs[2] = '{0,   1, 1, 0, 1,   0,  0};
    vecs[3] = '{129, 1, 1, 0, 1,   0,  0};
    vecs[4] = '{128, 1, 2, 8, 0, 112, 16};
    vecs[5] = '{1,   0, 0, 1, 0,   0,  1};
    vecs[6] = '{17,  2, 0, 2, 0,  16,  1};
    vecs[7] = '{255, 1, 1, 0, 1,   0,  0};
    vecs[8] = '{127, 1, 1, 8, 0, 112, 15};

    bus.op_start = 1'b0;
    bus.cfg_num_kernel = '0;
    #1 rst = 1'b1;
    #22 rst = 1'b0;
    tick();
    check("rst_status", int'(bus.status), 0);
    check("rst_op_done", int'(bus.op_done), 0);
    check("rst_op_err", int'(bus.op_err), 0);
    check("rst_rd_start", int'(bus.kern_rd_start), 0);
    check("rst_cl_start", int'(bus.cluster_start), 0);
    check("rst_kern_base", int'(bus.kern_base), 0);
    check("rst_kern_count", int'(bus.kern_count), 0);
    check("rst_pass_idx", int'(bus.pass_idx), 0);

    for (int i = 0; i < 9; i++) begin
      last_base = -1;
      last_count = -1;
      run_op(vecs[i].n, vecs[i].rd, vecs[i].cl, 0);
      check("vec_pass_count", rd_pulses, vecs[i].passes);
      check("vec_op_err", int'(bus.op_err), vecs[i].err);
      if (vecs[i].err == 0) begin
        check("vec_last_base", last_base, vecs[i].last_base);
        check("vec_last_count", last_count, vecs[i].last_count);
      end
    end

    // op_start during an op is ignored, then honoured in IDLE.
    run_op(40, 3, 3, 6);
    check("inject_passes", rd_pulses, 3);
    last_count = -1;
    run_op(5, 2, 2, 0);
    check("after_inject_count", last_count, 5);

    // Reset in CL_WAIT of pass 1.
    rd_busy = 2; cl_busy = 8;
    push_exp(40);
    exp_err = 0;
    rd_pulses = 0; cl_pulses = 0; done_pulses = 0; expect_rd = 1;
    @(posedge clk); #1;
    bus.op_start = 1'b1;
    bus.cfg_num_kernel = 8'd40;
    @(posedge clk); #1;
    bus.op_start = 1'b0;
    cyc = 0;
    while (cl_pulses < 2 && cyc < 500) begin
      tick();
      cyc++;
    end
    if (cl_pulses < 2) check("pass1_cluster_timeout", 0, 1);
    tick();
    tick();
    check("pre_rst_pass_idx", int'(bus.pass_idx), 1);
    rst = 1'b1;
    #1;
    check("arst_status", int'(bus.status), 0);
    check("arst_op_done", int'(bus.op_done), 0);
    check("arst_op_err", int'(bus.op_err), 0);
    check("arst_rd_start", int'(bus.kern_rd_start), 0);
    check("arst_cl_start", int'(bus.cluster_start), 0);
    check("arst_kern_base", int'(bus.kern_base), 0);
    check("arst_kern_count", int'(bus.kern_count), 0);
    check("arst_pass_idx", int'(bus.pass_idx), 0);
    exp_q.delete();
    tick();
    tick();
    rst = 1'b0;
    expect_rd = 1;
    rd_pulses = 0; cl_pulses = 0;
    for (int i = 0; i < 5; i++) tick();
    check("post_rst_no_rd", rd_pulses, 0);
    check("post_rst_no_cl", cl_pulses, 0);
    check("post_rst_status", int'(bus.status), 0);
    run_op(20, 2, 2, 0);
    check("post_rst_passes", rd_pulses, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
